csel_pipe_adder: RTL
====================

Name: csel_pipe_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor. It is the next generation of the team's 32-bit combinational csel adder.
- Operands are split into SEG-bit segments, and each pipeline stage resolves one segment.
- Valid/ready handshakes on both sides give one result per cycle at full throughput, with backpressure.
- Used as the datapath adder wherever a registered, stallable add/sub is needed.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of SEG.
- SEG, 8: segment width in bits. Each segment is one pipeline stage.
- NSEG, WIDTH/SEG: derived stage count. Not overridable. Must be at least 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for add; borrow-in for sub
- op  in  1  0 = add, 1 = sub (csel_pkg op_t)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum or difference
- cout  out  1  raw carry out of the MSB (for sub: 1 means no borrow)
- ovf  out  1  signed overflow

Behaviour:
- Reset (async, rst_n=0): all stage valid bits and all data registers clear to 0. out_valid=0, s=0, cout=0, ovf=0. in_ready=1 on the first cycle after rst_n rises.
- Operand prep at accept:
  - add: b_eff=b, c0=cin.
  - sub: b_eff=~b, c0=~cin. The result is a-b-cin mod 2^WIDTH.
- Handshake:
  - A transfer occurs when valid&&ready on a side.
  - Inputs are sampled only on in_valid&&in_ready.
  - The held result and out_valid stay stable while out_valid&&!out_ready.
- Pipeline structure:
  - Stages 0..NSEG-1. Stage k holds: valid_k, the resolved low result bits [k*SEG+SEG-1:0], the carry out of segment k, the unconsumed upper a/b_eff bits, and the sign bits of a and b_eff needed for ovf.
  - Stage k computes segment k on entry. It builds sum0 = a_seg+b_seg+0 and sum1 = a_seg+b_seg+1 in parallel, then selects by the incoming carry.
  - The incoming carry is c0 for k=0, otherwise the registered carry of stage k-1.
- Flow control per stage:
  - ready_NSEG = out_ready.
  - ready_k = !valid_k || ready_(k+1).
  - in_ready = ready_0.
  - This is a combinational chain. It collapses bubbles, so there is no throughput loss with gaps.
- Latency: NSEG cycles from input accept to out_valid when unstalled. That is 4 cycles at default parameters.
- Outputs are driven directly from the last stage registers. There is no combinational path from a/b to s.
- ovf = (a_msb == b_eff_msb) && (s_msb != a_msb).
- Boundary conditions:
  - Full: all stages valid and out_ready=0 gives in_ready=0. Inputs presented then are not consumed and must be held by the source.
  - Simultaneous accept at input and drain at output while full is allowed. Every stage advances in the same cycle.
  - Wrap: sums are mod 2^WIDTH. The carry appears on cout only.
  - Reset mid-operation discards all in-flight results. No partial output is emitted.
  - NSEG=1 degenerates to a single registered carry-select adder with latency 1.

Decomposition:
- csel_pkg holds:
  - op_t enum: OP_ADD=1'b0, OP_SUB=1'b1.
  - A localparam check function asserting WIDTH%SEG==0.
- Sub-module csel_segment (combinational, parameter SEG):
  - Inputs: a_seg, b_seg, c_in.
  - Outputs: s_seg, c_out.
  - Internally two SEG-bit adders plus a mux.
- The top instantiates NSEG csel_segment units, one per stage, via generate.

Test Plan:
- a=4, b=3, cin=0, op=add, out_ready=1 -> after 4 cycles out_valid=1, s=7, cout=0, ovf=0.
- a=32'hFFFF_FFFF, b=1, cin=0, add -> s=0, cout=1, ovf=0. Then a=32'h7FFF_FFFF, b=1 -> s=32'h8000_0000, ovf=1.
- op=sub, a=5, b=7, cin=0 -> s=32'hFFFF_FFFE, cout=0, ovf=0. Then a=7, b=5, cin=1 -> s=1, cout=1.
- Stream 10 back-to-back adds (a=i, b=i) with out_ready=1 -> 10 consecutive out_valid cycles with s=2i, in order. Then hold out_ready=0 -> in_ready falls after 4 accepts, outputs stay frozen; releasing out_ready drains in order with no loss or duplication.
- Assert rst_n=0 with 3 items in flight -> out_valid=0 and s=0 immediately (asynchronously). No stale result appears after rst_n rises.
- WIDTH=16, SEG=4: a=16'h8000, b=16'h8000, add -> latency 4, s=0, cout=1, ovf=1. With WIDTH=SEG=8, the same style of test gives latency 1.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared types and configuration helpers for the pipelined carry-select adder.
package csel_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // A legal configuration has a positive segment width that evenly tiles the operand.
  function automatic bit seg_cfg_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/csel_segment.sv
// One carry-select segment: both carry-in outcomes are summed in parallel and the
// real carry picks one, so the carry only ever passes through a mux.
module csel_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           c_in,
  output logic [SEG-1:0] s_seg,
  output logic           c_out
);

  logic [SEG:0] sum0;
  logic [SEG:0] sum1;

  always_comb begin
    sum0 = {1'b0, a_seg} + {1'b0, b_seg};
    sum1 = {1'b0, a_seg} + {1'b0, b_seg} + (SEG+1)'(1);
  end

  assign {c_out, s_seg} = c_in ? sum1 : sum0;

endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder/subtractor: stage k resolves segment k, with
// valid/ready flow control that lets bubbles collapse and stalls hold data in place.
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // An illegal WIDTH/SEG pair yields zero stages, which fails elaboration.
  localparam int NSEG  = seg_cfg_ok(WIDTH, SEG) ? WIDTH / SEG : 0;
  localparam int NPIPE = (NSEG > 1) ? NSEG - 1 : 1;

  logic [NSEG-1:0]  valid_q, valid_d;
  logic [NSEG-1:0]  carry_q, carry_d;
  logic [NSEG-1:0]  a_msb_q, a_msb_d;
  logic [NSEG-1:0]  b_msb_q, b_msb_d;
  logic [WIDTH-1:0] res_q [NSEG];
  logic [WIDTH-1:0] res_d [NSEG];
  logic [WIDTH-1:0] opa_q [NPIPE];
  logic [WIDTH-1:0] opa_d [NPIPE];
  logic [WIDTH-1:0] opb_q [NPIPE];
  logic [WIDTH-1:0] opb_d [NPIPE];

  logic [NSEG-1:0]  ready;
  logic [NSEG-1:0]  src_valid, src_carry, src_a_msb, src_b_msb, seg_carry;
  logic [WIDTH-1:0] src_a   [NSEG];
  logic [WIDTH-1:0] src_b   [NSEG];
  logic [WIDTH-1:0] src_res [NSEG];
  logic [SEG-1:0]   seg_sum [NSEG];
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    c0    = (op == OP_SUB) ? ~cin : cin;
  end

  // A stage can advance if it or any stage downstream of it is empty, or the sink drains.
  always_comb begin
    logic chain;
    chain = out_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      chain    = chain || !valid_q[k];
      ready[k] = chain;
    end
  end

  assign in_ready = ready[0];

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      if (k == 0) begin
        src_valid[k] = in_valid;
        src_a[k]     = a;
        src_b[k]     = b_eff;
        src_carry[k] = c0;
        src_res[k]   = '0;
        src_a_msb[k] = a[WIDTH-1];
        src_b_msb[k] = b_eff[WIDTH-1];
      end else begin
        src_valid[k] = valid_q[k-1];
        src_a[k]     = opa_q[k-1];
        src_b[k]     = opb_q[k-1];
        src_carry[k] = carry_q[k-1];
        src_res[k]   = res_q[k-1];
        src_a_msb[k] = a_msb_q[k-1];
        src_b_msb[k] = b_msb_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : gen_seg
    csel_segment #(.SEG(SEG)) u_seg (
      .a_seg (src_a[k][SEG-1:0]),
      .b_seg (src_b[k][SEG-1:0]),
      .c_in  (src_carry[k]),
      .s_seg (seg_sum[k]),
      .c_out (seg_carry[k])
    );
  end

  // Operands are shifted down as they travel so each stage always reads its segment at bit 0.
  always_comb begin
    logic load;
    for (int j = 0; j < NPIPE; j++) begin
      opa_d[j] = opa_q[j];
      opb_d[j] = opb_q[j];
    end
    for (int k = 0; k < NSEG; k++) begin
      load       = ready[k] && src_valid[k];
      valid_d[k] = ready[k] ? src_valid[k] : valid_q[k];
      res_d[k]   = load ? (src_res[k] | (WIDTH'(seg_sum[k]) << (k * SEG))) : res_q[k];
      carry_d[k] = load ? seg_carry[k] : carry_q[k];
      a_msb_d[k] = load ? src_a_msb[k] : a_msb_q[k];
      b_msb_d[k] = load ? src_b_msb[k] : b_msb_q[k];
      if ((k < NSEG - 1) && load) begin
        opa_d[k] = src_a[k] >> SEG;
        opb_d[k] = src_b[k] >> SEG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      a_msb_q <= '0;
      b_msb_q <= '0;
      for (int k = 0; k < NSEG; k++) res_q[k] <= '0;
      for (int j = 0; j < NPIPE; j++) begin
        opa_q[j] <= '0;
        opb_q[j] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      for (int k = 0; k < NSEG; k++) res_q[k] <= res_d[k];
      for (int j = 0; j < NPIPE; j++) begin
        opa_q[j] <= opa_d[j];
        opb_q[j] <= opb_d[j];
      end
    end
  end

  assign out_valid = valid_q[NSEG-1];
  assign s         = res_q[NSEG-1];
  assign cout      = carry_q[NSEG-1];
  assign ovf       = (a_msb_q[NSEG-1] == b_msb_q[NSEG-1]) && (s[WIDTH-1] != a_msb_q[NSEG-1]);

endmodule
